// File: rtl/smc_fp_pkg.sv
// Shared FP field widths, biases, FP16 special encodings and the pack FSM state type
// for the SMC FP32->FP16 writeback path.
package smc_fp_pkg;

  localparam int LANES      = 32;
  localparam int IN_SLICES  = 8;
  localparam int OUT_SLICES = 4;
  localparam int SLICE_W    = 4 * LANES;

  localparam int F16_EXP_W = 5;
  localparam int F16_MAN_W = 10;
  localparam int F32_EXP_W = 8;
  localparam int F32_MAN_W = 23;
  localparam int F16_BIAS  = 15;
  localparam int F32_BIAS  = 127;

  localparam logic [15:0] QNAN16 = 16'h7E00;
  localparam logic [15:0] INF16  = 16'h7C00;
  localparam logic [15:0] MAXF16 = 16'h7BFF;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_CONV = 2'd1,
    ST_OUT  = 2'd2
  } pack_state_e;

endpackage

// File: rtl/fp32_to_fp16_lane.sv
// Combinational single-lane FP32 -> FP16 converter with RNE rounding and exception flags.
// Define FP32TO16_SAT_EN to saturate finite overflows to max-normal instead of infinity.
module fp32_to_fp16_lane
  import smc_fp_pkg::*;
(
  input  logic [31:0] fp32_i,
  output logic [15:0] fp16_o,
  output logic        ovf_o,
  output logic        unf_o,
  output logic        inx_o
);

`ifdef FP32TO16_SAT_EN
  localparam logic [14:0] OVF_MAG = MAXF16[14:0];
`else
  localparam logic [14:0] OVF_MAG = INF16[14:0];
`endif

  logic               sgn;
  logic [7:0]         e8;
  logic [22:0]        man;
  logic signed [9:0]  exp_u;
  logic [9:0]         sub_amt;
  logic [46:0]        sub_v;
  logic [14:0]        mag_sum;
  logic               guard;
  logic               sticky;
  logic               rnd_up;

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    sgn     = fp32_i[31];
    e8      = fp32_i[30:23];
    man     = fp32_i[22:0];
    exp_u   = $signed({2'b00, e8}) - 10'sd112;
    sub_amt = 10'(10'sd1 - exp_u);
    sub_v   = '0;
    mag_sum = '0;
    guard   = 1'b0;
    sticky  = 1'b0;
    rnd_up  = 1'b0;
    fp16_o  = {sgn, 15'h0};
    ovf_o   = 1'b0;
    unf_o   = 1'b0;
    inx_o   = 1'b0;

    if (e8 == 8'hFF) begin
      fp16_o = (man != '0) ? {sgn, QNAN16[14:0]} : {sgn, INF16[14:0]};
    end else if (e8 == 8'h00) begin
      fp16_o = {sgn, 15'h0};
    end else if (exp_u >= 10'sd1) begin
      guard   = man[12];
      sticky  = |man[11:0];
      rnd_up  = guard & (sticky | man[13]);
      inx_o   = guard | sticky;
      mag_sum = {exp_u[4:0], man[22:13]} + {14'b0, rnd_up};
      // A mantissa carry walks into the exponent field; all-ones exponent means overflow.
      if (exp_u >= 10'sd31 || mag_sum[14:10] == 5'h1F) begin
        ovf_o  = 1'b1;
        inx_o  = 1'b1;
        fp16_o = {sgn, OVF_MAG};
      end else begin
        fp16_o = {sgn, mag_sum};
      end
    end else if (sub_amt >= 10'd25) begin
      unf_o = 1'b1;
      inx_o = 1'b1;
    end else begin
      // Pre-scaled so the 10b subnormal field lands at [46:37] with nothing lost below bit 0.
      sub_v   = {1'b1, man, 23'b0} >> (sub_amt[4:0] - 5'd1);
      guard   = sub_v[36];
      sticky  = |sub_v[35:0];
      rnd_up  = guard & (sticky | sub_v[37]);
      mag_sum = {5'b0, sub_v[46:37]} + {14'b0, rnd_up};
      fp16_o  = {sgn, mag_sum};
      inx_o   = guard | sticky;
      unf_o   = guard | sticky;
    end
  end

endmodule

// File: rtl/fp32to16_pack.sv
// Collects 8 nibble-interleaved FP32 slices, converts 32 lanes to FP16 and presents them as
// 4 nibble-interleaved slices over valid/ready. FP32TO16_SAT_EN selects saturating overflow.
module fp32to16_pack
  import smc_fp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic [SLICE_W-1:0]   in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [SLICE_W-1:0]   out_d0,
  output logic [SLICE_W-1:0]   out_d1,
  output logic [SLICE_W-1:0]   out_d2,
  output logic [SLICE_W-1:0]   out_d3,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 flag_ovf,
  output logic                 flag_unf,
  output logic                 flag_inx
);

  pack_state_e          state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [SLICE_W-1:0]   slice_q [IN_SLICES];
  logic [31:0]          lane_in  [LANES];
  logic [15:0]          lane_out [LANES];
  logic [LANES-1:0]     lane_ovf, lane_unf, lane_inx;
  logic [SLICE_W-1:0]   pack_d [OUT_SLICES];
  logic                 accept;
  logic                 load_out;

  assign in_ready  = (state_q == ST_LOAD);
  assign out_valid = (state_q == ST_OUT);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_out = 1'b0;
    if (clr) begin
      state_d = ST_LOAD;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_LOAD: if (accept) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'(IN_SLICES - 1)) state_d = ST_CONV;
        end
        ST_CONV: begin
          load_out = 1'b1;
          state_d  = ST_OUT;
        end
        ST_OUT:  if (out_ready) state_d = ST_LOAD;
        default: state_d = ST_LOAD;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: slice storage is deliberately unreset; it is always fully rewritten before CONV reads it.
  always_ff @(posedge clk) begin
    if (accept && !clr) slice_q[cnt_q] <= in_data;
  end

  always_comb begin
    for (int k = 0; k < LANES; k++)
      for (int j = 0; j < IN_SLICES; j++)
        lane_in[k][4*j +: 4] = slice_q[j][4*k +: 4];
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    fp32_to_fp16_lane u_lane (
      .fp32_i (lane_in[k]),
      .fp16_o (lane_out[k]),
      .ovf_o  (lane_ovf[k]),
      .unf_o  (lane_unf[k]),
      .inx_o  (lane_inx[k])
    );
  end

  always_comb begin
    for (int j = 0; j < OUT_SLICES; j++)
      for (int k = 0; k < LANES; k++)
        pack_d[j][4*k +: 4] = lane_out[k][4*j +: 4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_d0   <= '0;
      out_d1   <= '0;
      out_d2   <= '0;
      out_d3   <= '0;
      flag_ovf <= 1'b0;
      flag_unf <= 1'b0;
      flag_inx <= 1'b0;
    end else if (load_out) begin
      out_d0   <= pack_d[0];
      out_d1   <= pack_d[1];
      out_d2   <= pack_d[2];
      out_d3   <= pack_d[3];
      flag_ovf <= |lane_ovf;
      flag_unf <= |lane_unf;
      flag_inx <= |lane_inx;
    end
  end

endmodule

// File: tb/tb_fp32to16_pack.sv
// Self-checking bench for fp32to16_pack: directed vector table, handshake/abort/reset
// sequences and randomized batches against a quantum-based rounding model.
module tb_fp32to16_pack;
  import smc_fp_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         clr = 1'b0;
  logic [127:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_ready, out_valid, flag_ovf, flag_unf, flag_inx;
  logic [127:0] out_d0, out_d1, out_d2, out_d3;

  int total = 0;
  int bad   = 0;
  logic [31:0] cur [32];

  typedef struct {
    logic [31:0] in;
    logic [15:0] exp;
  } vec_t;
  vec_t vt [15];

  always #5 clk = ~clk;

  fp32to16_pack dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_d0    (out_d0),
    .out_d1    (out_d1),
    .out_d2    (out_d2),
    .out_d3    (out_d3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .flag_ovf  (flag_ovf),
    .flag_unf  (flag_unf),
    .flag_inx  (flag_inx)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: round the exact value to a multiple of the FP16 quantum at its binade.
  function automatic void model(input logic [31:0] x, output logic [15:0] r,
                                output logic ovf, output logic unf, output logic inx);
    int     e8, ue, sh, bits;
    longint sig, n, rem, half;
    logic   s;
    s = x[31];
    e8 = int'(x[30:23]);
    ovf = 1'b0; unf = 1'b0; inx = 1'b0;
    r = {s, 15'h0};
    if (e8 == 255) begin
      r = (x[22:0] != 0) ? {s, 15'h7E00} : {s, 15'h7C00};
    end else if (e8 != 0) begin
      sig = longint'({1'b1, x[22:0]});
      ue  = e8 - 127;
      sh  = (ue >= -14) ? 13 : 126 - e8;
      if (sh > 40) begin
        n = 0;
        inx = 1'b1;
      end else begin
        n    = sig >> sh;
        rem  = sig - (n << sh);
        half = longint'(1) << (sh - 1);
        if (rem > half || (rem == half && n[0])) n++;
        inx = (rem != 0);
      end
      bits = (ue >= -14) ? ((ue + 15) << 10) + int'(n) - 1024 : int'(n);
      unf = inx && (ue < -14);
      if (bits >= 'h7C00) begin
        ovf = 1'b1;
        inx = 1'b1;
`ifdef FP32TO16_SAT_EN
        r = {s, 15'h7BFF};
`else
        r = {s, 15'h7C00};
`endif
      end else begin
        r = {s, bits[14:0]};
      end
    end
  endfunction

  function automatic logic [127:0] slice_of(input int j);
    logic [127:0] d;
    for (int k = 0; k < 32; k++) d[4*k +: 4] = cur[k][4*j +: 4];
    return d;
  endfunction

  function automatic logic [15:0] lane_res(input int k);
    return {out_d3[4*k +: 4], out_d2[4*k +: 4], out_d1[4*k +: 4], out_d0[4*k +: 4]};
  endfunction

  function automatic logic [31:0] rand_lane();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 3))
      0: ;
      1: w[30:23] = 8'($urandom_range(100, 145));
      2: w[30:23] = 8'($urandom_range(80, 115));
      default: begin
        w[30:23] = 8'($urandom_range(95, 143));
        w[12:0]  = 13'h1000;
      end
    endcase
    return w;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic push_slice(input logic [127:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 128'(in_ready), 128'(1));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_batch(input int gap);
    for (int j = 0; j < 8; j++) begin
      repeat (gap) @(negedge clk);
      push_slice(slice_of(j));
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_out_valid"}, 128'(out_valid), 128'(1));
  endtask

  task automatic compare_batch(input string tag);
    logic [15:0] r;
    logic o, u, i, ao, au, ai;
    ao = 1'b0; au = 1'b0; ai = 1'b0;
    for (int k = 0; k < 32; k++) begin
      model(cur[k], r, o, u, i);
      ao |= o; au |= u; ai |= i;
      check($sformatf("%s_lane%0d_in%h", tag, k, cur[k]), 128'(lane_res(k)), 128'(r));
    end
    check({tag, "_flags"}, 128'({flag_ovf, flag_unf, flag_inx}), 128'({ao, au, ai}));
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_done_valid"}, 128'(out_valid), 128'(0));
    check({tag, "_done_ready"}, 128'(in_ready), 128'(1));
  endtask

  initial begin
    logic [127:0] snap0, snap1, snap2, snap3;
    logic stable, spurious;

    vt[0]  = '{32'h3F800000, 16'h3C00};
    vt[1]  = '{32'h477FE000, 16'h7BFF};
`ifdef FP32TO16_SAT_EN
    vt[2]  = '{32'h477FF000, 16'h7BFF};
`else
    vt[2]  = '{32'h477FF000, 16'h7C00};
`endif
    vt[3]  = '{32'h7FC00000, 16'h7E00};
    vt[4]  = '{32'hFF800000, 16'hFC00};
    vt[5]  = '{32'h3F801000, 16'h3C00};
    vt[6]  = '{32'h3F803000, 16'h3C02};
    vt[7]  = '{32'h33800000, 16'h0001};
    vt[8]  = '{32'h33000000, 16'h0000};
    vt[9]  = '{32'h00000000, 16'h0000};
    vt[10] = '{32'h80000001, 16'h8000};
    vt[11] = '{32'h7F800001, 16'h7E00};
    vt[12] = '{32'hC0000000, 16'hC000};
    vt[13] = '{32'h38800000, 16'h0400};
    vt[14] = '{32'h387FF000, 16'h0400};

    #1 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_d", out_d0 | out_d1 | out_d2 | out_d3, 128'(0));
    check("rst_flags", 128'({flag_ovf, flag_unf, flag_inx}), 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // All lanes 1.0, back-to-back, with latency check.
    for (int k = 0; k < 32; k++) cur[k] = 32'h3F800000;
    send_batch(0);
    check("lat_after_last", 128'(out_valid), 128'(0));
    @(negedge clk);
    check("lat_plus_one", 128'(out_valid), 128'(1));
    wait_valid("one");
    for (int k = 0; k < 32; k++) check($sformatf("one_lane%0d", k), 128'(lane_res(k)), 128'(16'h3C00));
    check("one_flags", 128'({flag_ovf, flag_unf, flag_inx}), 128'(0));
    release_out("one");

    // Directed vector table.
    for (int k = 0; k < 32; k++) cur[k] = vt[k % 15].in;
    send_batch(0);
    wait_valid("tbl");
    for (int k = 0; k < 32; k++)
      check($sformatf("tbl_lane%0d_in%h", k, vt[k % 15].in), 128'(lane_res(k)), 128'(vt[k % 15].exp));
    compare_batch("tbl_model");
    release_out("tbl");

    // Underflow-only and overflow-only batches.
    for (int k = 0; k < 32; k++) cur[k] = 32'h33000000;
    send_batch(0);
    wait_valid("unf");
    check("unf_lane0", 128'(lane_res(0)), 128'(16'h0000));
    check("unf_flags", 128'({flag_ovf, flag_unf, flag_inx}), 128'(3'b011));
    release_out("unf");

    for (int k = 0; k < 32; k++) cur[k] = 32'h477FF000;
    send_batch(0);
    wait_valid("ovf");
    check("ovf_flags", 128'({flag_ovf, flag_unf, flag_inx}), 128'(3'b101));
    release_out("ovf");

    // Gapped input, consumer stalls 5 cycles while a producer keeps offering junk.
    for (int k = 0; k < 32; k++) cur[k] = rand_lane();
    send_batch(2);
    wait_valid("hold");
    snap0 = out_d0; snap1 = out_d1; snap2 = out_d2; snap3 = out_d3;
    stable = 1'b1;
    in_valid = 1'b1;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    repeat (5) begin
      @(negedge clk);
      if (!out_valid || in_ready || out_d0 !== snap0 || out_d1 !== snap1 ||
          out_d2 !== snap2 || out_d3 !== snap3) stable = 1'b0;
    end
    in_valid = 1'b0;
    check("hold_stable", 128'(stable), 128'(1));
    compare_batch("hold");
    release_out("hold");
    for (int k = 0; k < 32; k++) cur[k] = rand_lane();
    send_batch(1);
    wait_valid("after_hold");
    compare_batch("after_hold");
    release_out("after_hold");

    // Abort after 5 slices, then a clean batch.
    for (int k = 0; k < 32; k++) cur[k] = rand_lane();
    for (int j = 0; j < 5; j++) push_slice(slice_of(j));
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_ready", 128'(in_ready), 128'(1));
    check("clr_valid", 128'(out_valid), 128'(0));
    for (int k = 0; k < 32; k++) cur[k] = rand_lane();
    spurious = 1'b0;
    for (int j = 0; j < 8; j++) begin
      push_slice(slice_of(j));
      if (j < 7 && out_valid) spurious = 1'b1;
    end
    check("clr_no_spurious", 128'(spurious), 128'(0));
    wait_valid("clr");
    compare_batch("clr");
    release_out("clr");

    // Randomized batches.
    for (int b = 0; b < 6; b++) begin
      for (int k = 0; k < 32; k++) cur[k] = rand_lane();
      send_batch(b % 2);
      wait_valid($sformatf("rnd%0d", b));
      compare_batch($sformatf("rnd%0d", b));
      release_out($sformatf("rnd%0d", b));
    end

    // Asynchronous reset while holding a result.
    for (int k = 0; k < 32; k++) cur[k] = 32'h3F800000;
    send_batch(0);
    wait_valid("arst");
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 128'(out_valid), 128'(0));
    check("arst_ready", 128'(in_ready), 128'(1));
    check("arst_out_d", out_d0 | out_d1 | out_d2 | out_d3, 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 32; k++) cur[k] = rand_lane();
    send_batch(0);
    wait_valid("post_rst");
    compare_batch("post_rst");
    release_out("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
